// File: rtl/wb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master_if
// Brief    : Command, write/read data streams and Wishbone master bus bundle
// Revision : 1.0
// ============================================================================
interface wb_burst_master_if #(
  parameter int aw = 32,
  parameter int dw = 32
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [aw-1:0]   cmd_addr;
  logic            cmd_we;
  logic [7:0]      cmd_len;
  logic            wdata_valid;
  logic            wdata_ready;
  logic [dw-1:0]   wdata;
  logic            rdata_valid;
  logic [dw-1:0]   rdata;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [aw-1:0]   wb_addr_i;
  logic [dw-1:0]   wb_dat_i;
  logic [dw/8-1:0] wb_sel_i;
  logic [2:0]      wb_cti_i;
  logic            wb_ack_o;
  logic [dw-1:0]   wb_dat_o;

  modport master (
    input  cmd_valid, cmd_addr, cmd_we, cmd_len,
    output cmd_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata,
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_we, cmd_len,
    input  cmd_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata,
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    output wb_ack_o, wb_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master
// Brief    : Turns addr/len commands into Wishbone incrementing bursts toward
//            an SDRAM controller. Optional macro WB_ACK_TIMEOUT_EN adds an
//            ack watchdog that aborts a stalled burst and pulses err.
// Revision : 1.0
// ============================================================================
module wb_burst_master #(
  parameter int aw = 32,
  parameter int dw = 32
) (
  input  wire logic         sys_clk,
  input  wire logic         RESETN,
  input  wire logic         sdr_init_done,
  wb_burst_master_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [aw-1:0]   c_stride  = aw'(dw / 8);
  localparam logic [dw/8-1:0] c_sel_all = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [aw-1:0] r_addr;
  logic          r_we;
  logic [7:0]    r_left;       // beats remaining after the current one
  logic          r_single;
  logic          r_rdata_valid;
  logic [dw-1:0] r_rdata;

  logic          w_in_burst;
  logic          w_last;
  logic          w_stb;
  logic          w_beat;
  logic          w_accept;
  logic          w_timeout;

  assign w_in_burst = (r_state == S_BURST);
  assign w_last     = (r_left == 8'd0);

  // Bus-facing decode depends only on state and registered context, never on
  // ack, so the slave may answer combinationally without forming a loop.
  always_comb begin : p_bus_out
    w_stb         = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wb_cyc_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
    bus.wb_addr_i = '0;
    bus.wb_dat_i  = '0;
    bus.wb_sel_i  = '0;
    bus.wb_cti_i  = 3'b000;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = sdr_init_done & RESETN;
      end
      S_BURST: begin
        busy          = 1'b1;
        bus.wb_cyc_i  = 1'b1;
        w_stb         = r_we ? bus.wdata_valid : 1'b1;
        bus.wb_we_i   = r_we;
        bus.wb_addr_i = r_addr;
        bus.wb_dat_i  = r_we ? bus.wdata : '0;
        bus.wb_sel_i  = c_sel_all;
        if (r_single)
          bus.wb_cti_i = 3'b000;
        else if (w_last)
          bus.wb_cti_i = 3'b111;
        else
          bus.wb_cti_i = 3'b010;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.wb_stb_i    = w_stb;
  assign w_beat          = w_in_burst & w_stb & bus.wb_ack_o;
  assign w_accept        = bus.cmd_valid & bus.cmd_ready;
  assign bus.wdata_ready = w_beat & r_we;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.rdata       = r_rdata;

  always_ff @(posedge sys_clk) begin : p_state
    if (!RESETN)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin : p_next
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = S_BURST;
      end
      S_BURST: begin
        if (w_beat && w_last)
          w_next = S_DONE;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin : p_datapath
    if (!RESETN) begin
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_left        <= 8'd0;
      r_single      <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rdata_valid <= w_beat & ~r_we;
      if (w_beat && !r_we)
        r_rdata <= bus.wb_dat_o;
      if (w_accept) begin
        r_addr   <= bus.cmd_addr;
        r_we     <= bus.cmd_we;
        // A zero length still moves one beat.
        r_left   <= (bus.cmd_len == 8'd0) ? 8'd0 : bus.cmd_len - 8'd1;
        r_single <= (bus.cmd_len <= 8'd1);
      end else if (w_beat) begin
        r_addr <= r_addr + c_stride;
        if (!w_last)
          r_left <= r_left - 8'd1;
      end
    end
  end

`ifdef WB_ACK_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;

  // The 255th consecutive unacked strobe cycle is the one that trips.
  assign w_timeout = w_in_burst & w_stb & ~bus.wb_ack_o & (r_wdog == 8'd254);

  always_ff @(posedge sys_clk) begin : p_wdog
    if (!RESETN) begin
      r_wdog <= 8'd0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_in_burst && w_stb && !bus.wb_ack_o && !w_timeout)
        r_wdog <= r_wdog + 8'd1;
      else
        r_wdog <= 8'd0;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_master
// Brief    : Vector table of bursts checked through a beat/read-data scoreboard
// Revision : 1.0
// ============================================================================
module tb_wb_burst_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic sys_clk       = 1'b0;
  logic RESETN        = 1'b0;
  logic sdr_init_done = 1'b0;
  logic busy;
  logic done;
  logic err;

  wb_burst_master_if #(.aw(AW), .dw(DW)) bus ();

  wb_burst_master #(.aw(AW), .dw(DW)) dut (
    .sys_clk       (sys_clk),
    .RESETN        (RESETN),
    .sdr_init_done (sdr_init_done),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave model: ack on strobe (or on any cyc cycle when loose), data from address
  logic ack_en    = 1'b1;
  logic ack_loose = 1'b0;

  function automatic logic [31:0] rmodel(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] wmodel(input logic [31:0] a, input int i);
    return {a[15:0] ^ 16'h5A5A, i[15:0]};
  endfunction

  assign bus.wb_ack_o = ack_en & bus.wb_cyc_i & (bus.wb_stb_i | ack_loose);
  assign bus.wb_dat_o = rmodel(bus.wb_addr_i);

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    int          gap_after;
    int          gap_len;
    logic        loose;
    logic        drop_init;
  } vec_t;

  beat_t exp_q[$];
  rd_t   rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int last_ack_cyc = -10;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int beat_cnt = 0;
  int wrdy_cnt = 0;
  int nostb_cnt = 0;
  int stb_rise_cyc = -1;
  logic prev_stb = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not match the expected sequence", name);
  endtask

  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  // Monitor: samples on the falling edge, pops the scoreboard on every beat
  always @(negedge sys_clk) begin
    beat_t e;
    rd_t   r;
    if (RESETN) begin
      if (bus.wb_cyc_i && bus.wb_stb_i && bus.wb_ack_o) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          fail("beat_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", bus.wb_addr_i, e.addr);
          check("beat_cti", bus.wb_cti_i, e.cti);
          check("beat_we", bus.wb_we_i, e.we);
          check("beat_sel", bus.wb_sel_i, 4'hF);
          if (e.we) begin
            check("beat_wdat", bus.wb_dat_i, e.data);
          end else begin
            r.data = rmodel(e.addr);
            r.cyc  = cyc_n + 1;
            rd_q.push_back(r);
          end
          if (e.cti != 3'b010)
            last_ack_cyc = cyc_n;
        end
      end
      if (bus.rdata_valid) begin
        if (rd_q.size() == 0) begin
          fail("rdata_unexpected");
        end else begin
          r = rd_q.pop_front();
          check("rdata_value", bus.rdata, r.data);
          check("rdata_cycle", cyc_n, r.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_latency", cyc_n, last_ack_cyc + 1);
        check("done_busy", busy, 1);
        check("done_cyc_low", bus.wb_cyc_i, 0);
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc_n;
        check("err_bus_released", {bus.wb_cyc_i, bus.wb_stb_i, done}, 0);
      end
      if (bus.wdata_ready)
        wrdy_cnt++;
      if (bus.wb_cyc_i && !bus.wb_stb_i)
        nostb_cnt++;
      if (bus.wb_cyc_i && bus.cmd_ready)
        fail("cmd_ready_in_burst");
      if (bus.wb_stb_i && !prev_stb)
        stb_rise_cyc = cyc_n;
    end
    prev_stb = bus.wb_stb_i;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] len);
    int n;
    bit ok;
    n  = (len == 8'd0) ? 1 : int'(len);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.addr = addr + 32'(4 * i);
      e.cti  = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      e.we   = we;
      e.data = we ? wmodel(addr, i) : 32'h0;
      exp_q.push_back(e);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    for (int k = 0; k < 100; k++) begin
      @(negedge sys_clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      fail("cmd_accept_timeout");
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] addr, input int n, input int gap_after, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_after && gap_len > 0) begin
        bus.wdata_valid = 1'b0;
        repeat (gap_len) @(posedge sys_clk);
        #1;
      end
      bus.wdata_valid = 1'b1;
      bus.wdata       = wmodel(addr, i);
      for (int k = 0; k < 200; k++) begin
        @(negedge sys_clk);
        if (bus.wdata_ready)
          break;
      end
      tick();
    end
    bus.wdata_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen)
      fail("done_timeout");
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int viol;
    int d0;
    vecs[0] = '{we: 1'b1, addr: 32'h0000_0100, len: 8'd4, gap_after: -1, gap_len: 0, loose: 1'b0, drop_init: 1'b0};
    vecs[1] = '{we: 1'b0, addr: 32'h0000_0000, len: 8'd1, gap_after: -1, gap_len: 0, loose: 1'b0, drop_init: 1'b0};
    vecs[2] = '{we: 1'b1, addr: 32'h0000_0200, len: 8'd3, gap_after: 1,  gap_len: 5, loose: 1'b1, drop_init: 1'b0};
    vecs[3] = '{we: 1'b0, addr: 32'hFFFF_FFFC, len: 8'd2, gap_after: -1, gap_len: 0, loose: 1'b0, drop_init: 1'b0};
    vecs[4] = '{we: 1'b1, addr: 32'h0000_0040, len: 8'd0, gap_after: -1, gap_len: 0, loose: 1'b0, drop_init: 1'b0};
    vecs[5] = '{we: 1'b0, addr: 32'h0000_1000, len: 8'd8, gap_after: -1, gap_len: 0, loose: 1'b0, drop_init: 1'b1};

    bus.cmd_valid   = 1'b0;
    bus.cmd_we      = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_wb_outputs", {bus.wb_cyc_i, bus.wb_stb_i, bus.wb_we_i, bus.wb_cti_i}, 0);
    check("rst_wb_addr", bus.wb_addr_i, 0);
    check("rst_status", {busy, done, err, bus.cmd_ready, bus.wdata_ready, bus.rdata_valid}, 0);
    check("rst_rdata", bus.rdata, 0);

    tick();
    RESETN = 1'b1;
    tick();

    // Controller not initialised: command must be held off
    viol = 0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge sys_clk);
      if (bus.cmd_ready || bus.wb_cyc_i)
        viol++;
    end
    check("no_init_holdoff", viol, 0);
    tick();
    bus.cmd_valid = 1'b0;
    sdr_init_done = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      int n;
      n         = (vecs[v].len == 8'd0) ? 1 : int'(vecs[v].len);
      ack_loose = vecs[v].loose;
      beat_cnt  = 0;
      wrdy_cnt  = 0;
      nostb_cnt = 0;
      issue(vecs[v].we, vecs[v].addr, vecs[v].len);
      if (vecs[v].drop_init)
        sdr_init_done = 1'b0;
      fork
        if (vecs[v].we) feed(vecs[v].addr, n, vecs[v].gap_after, vecs[v].gap_len);
        wait_done();
      join
      sdr_init_done = 1'b1;
      ack_loose     = 1'b0;
      tick();
      check($sformatf("v%0d_beats", v), beat_cnt, n);
      check($sformatf("v%0d_wdata_ready", v), wrdy_cnt, vecs[v].we ? n : 0);
      check($sformatf("v%0d_stb_gap", v), nostb_cnt, vecs[v].gap_len);
      check($sformatf("v%0d_beats_left", v), exp_q.size(), 0);
      check($sformatf("v%0d_reads_left", v), rd_q.size(), 0);
    end

    // Reset in the middle of a stalled burst
    ack_en = 1'b0;
    d0 = done_cnt;
    issue(1'b0, 32'h0000_0300, 8'd4);
    tick();
    tick();
    check("pre_rst_cyc", bus.wb_cyc_i, 1);
    RESETN = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("mid_rst_outputs",
          {bus.wb_cyc_i, bus.wb_stb_i, busy, done, err, bus.cmd_ready, bus.rdata_valid, bus.wdata_ready}, 0);
    check("mid_rst_addr", bus.wb_addr_i, 0);
    exp_q.delete();
    tick();
    RESETN = 1'b1;
    ack_en = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", done_cnt, d0);

`ifdef WB_ACK_TIMEOUT_EN
    begin
      bit seen;
      seen   = 1'b0;
      ack_en = 1'b0;
      d0     = done_cnt;
      issue(1'b0, 32'h0000_0040, 8'd2);
      for (int k = 0; k < 400; k++) begin
        @(negedge sys_clk);
        if (err) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen)
        fail("err_timeout");
      tick();
      check("wdog_latency", err_cyc - stb_rise_cyc, 255);
      check("wdog_err_count", err_cnt, 1);
      check("wdog_no_done", done_cnt, d0);
      exp_q.delete();
      ack_en   = 1'b1;
      beat_cnt = 0;
      issue(1'b0, 32'h0000_0080, 8'd1);
      wait_done();
      tick();
      check("post_abort_beats", beat_cnt, 1);
      check("post_abort_reads_left", rd_q.size(), 0);
    end
`else
    check("err_never", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
